// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a prefetch queue.
//
// Issues word-aligned requests to instruction memory over a valid/ready
// request channel. Responses come back in order. Up to DEPTH instructions
// are held in a FIFO of {pc, ins} pairs. Queued entries plus outstanding
// requests never exceed DEPTH, so a push never finds the queue full.
// A redirect (taken branch/jump) empties the queue and marks every response
// still in flight to be dropped.
//
// Parameters:
//   DEPTH    : credit limit (queued + outstanding). Power of two, >= 2.
//   RESET_PC : first fetch address after reset (word-aligned).
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   redirect_valid, redirect_pc      flush and refetch from redirect_pc & ~3
//   imem_req_valid/_addr/_ready      fetch request channel
//   imem_rsp_valid/_data             in-order fetch responses
//   ins_valid, ins, pc_out           queue head presented to decode
//   ins_ready                        decode consumes the head this cycle
//
// Optional feature: define FETCH_BYPASS_EN to forward a kept response
// straight to ins/pc_out when the queue is empty (zero-cycle latency).
// Without it, ins/pc_out always come from the queue registers.

module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic [31:0] pc_out,
    input  logic        ins_ready
);

    localparam int          CW     = $clog2(DEPTH + 1);
    localparam int          PW     = $clog2(DEPTH);
    localparam logic [CW:0] CREDIT = (CW + 1)'(DEPTH);

    // run_q holds request issue off while reset is asserted; it sets on the
    // first clock edge after reset is released.
    logic          run_q, run_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [31:0]   pc_mem_q  [DEPTH];
    logic [31:0]   ins_mem_q [DEPTH];

    logic          req_fire;
    logic          rsp_fire;
    logic          keep;
    logic          bypass;
    logic          pop_fire;
    logic          deq;
    logic          push;
    logic [CW:0]   occupancy;
    logic [31:0]   redirect_base;

    always_comb begin
        occupancy      = {1'b0, count_q} + {1'b0, inflight_q};
        imem_req_valid = run_q && (occupancy < CREDIT) && !redirect_valid;
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol error; ignore it.
        rsp_fire       = imem_rsp_valid && (inflight_q != '0);
        keep           = rsp_fire && (discard_q == '0) && !redirect_valid;
`ifdef FETCH_BYPASS_EN
        bypass         = keep && (count_q == '0);
`else
        bypass         = 1'b0;
`endif
        ins_valid      = (count_q != '0) || bypass;
        if (bypass) begin
            ins    = imem_rsp_data;
            pc_out = rsp_pc_q;
        end else begin
            ins    = ins_mem_q[head_q];
            pc_out = pc_mem_q[head_q];
        end
        pop_fire       = ins_valid && ins_ready && !redirect_valid;
        deq            = pop_fire && (count_q != '0);
        // A bypassed response consumed this cycle never enters the queue.
        push           = keep && !(bypass && ins_ready);
        redirect_base  = redirect_pc & 32'hFFFF_FFFC;

        run_d      = 1'b1;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);
        discard_d  = discard_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_base;
            rsp_pc_d   = redirect_base;
            // No request issues in a redirect cycle, so this equals the
            // outstanding count after any response arriving now.
            discard_d  = inflight_d;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (keep) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (rsp_fire && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(deq);
            head_d  = head_q + PW'(deq);
            tail_d  = tail_q + PW'(push);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else begin
            run_q      <= run_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (push) begin
                pc_mem_q[tail_q]  <= rsp_pc_q;
                ins_mem_q[tail_q] <= imem_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. A memory model answers requests in order with a
// randomly gated one-or-more-cycle latency; a queue-level reference model
// predicts the request channel and the decode-side outputs every cycle.

module tb_fetch_unit;

    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] pc_out;
    logic        ins_ready = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ins_valid      (ins_valid),
        .ins            (ins),
        .pc_out         (pc_out),
        .ins_ready      (ins_ready)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_fpc = '0;
    logic [31:0] m_rpc = '0;
    int          m_disc = 0;
    logic [31:0] pend[$];
    logic [31:0] mq_pc[$];
    logic [31:0] mq_ins[$];
    logic [31:0] got_pc[$];
    int          n_acc = 0;
    logic        s_iv, s_rv;
    logic [31:0] s_ra;

    function automatic logic [31:0] memf(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy,
                         input bit irdy, input bit rsp_en);
        bit          rsp, keep, byp, exp_rv, exp_iv;
        logic [31:0] raddr, rd;
        @(negedge clk);
        rsp    = rsp_en && (pend.size() > 0);
        exp_rv = ((mq_pc.size() + pend.size()) < DEPTH) && !redir;
        if (rsp) begin
            raddr = pend.pop_front();
            rd    = memf(raddr);
        end else begin
            rd = $urandom;
        end
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        ins_ready      = irdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rd;
        keep   = rsp && (m_disc == 0) && !redir;
        byp    = BYP && keep && (mq_pc.size() == 0);
        exp_iv = (mq_pc.size() != 0) || byp;
        #1;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        chk("req_addr", imem_req_addr, m_fpc);
        chk("ins_valid", 32'(ins_valid), 32'(exp_iv));
        if (mq_pc.size() != 0) begin
            chk("pc_out", pc_out, mq_pc[0]);
            chk("ins", ins, mq_ins[0]);
        end else if (byp) begin
            chk("pc_out_byp", pc_out, m_rpc);
            chk("ins_byp", ins, rd);
        end
        s_iv = ins_valid;
        s_rv = imem_req_valid;
        s_ra = imem_req_addr;
        if (ins_valid && irdy && !redir) got_pc.push_back(pc_out);
        if (imem_req_valid && rdy) n_acc++;
        if (redir) begin
            mq_pc.delete();
            mq_ins.delete();
            m_disc = pend.size();
            m_fpc  = rpc & ~32'd3;
            m_rpc  = rpc & ~32'd3;
        end else begin
            if (exp_iv && irdy && (mq_pc.size() != 0)) begin
                void'(mq_pc.pop_front());
                void'(mq_ins.pop_front());
            end
            if (keep && !(byp && irdy)) begin
                mq_pc.push_back(m_rpc);
                mq_ins.push_back(rd);
            end
            if (keep) m_rpc = m_rpc + 32'd4;
            if (rsp && (m_disc > 0)) m_disc--;
            if (exp_rv && rdy) begin
                pend.push_back(m_fpc);
                m_fpc = m_fpc + 32'd4;
            end
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        return (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        bit stale;
        // Reset state
        #12;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_ins_valid", 32'(ins_valid), 32'd0);
        chk("rst_ins", ins, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        // Steady streaming, latency 1, decode always ready
        got_pc.delete();
        repeat (12) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("steady_count", 32'(got_pc.size()), BYP ? 32'd11 : 32'd10);
        for (int i = 0; i < 4; i++) chk("steady_seq", got_at(i), 32'(i * 4));

        // Decode stalled: credit limit caps accepted requests at DEPTH
        cycle(1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        got_pc.delete();
        n_acc = 0;
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("stall_accepted", 32'(n_acc), 32'(DEPTH));
        chk("stall_req_low", 32'(s_rv), 32'd0);
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("drain_count", 32'(got_pc.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("drain_seq", got_at(i), 32'(i * 4));

        // Redirect with one queued entry and two requests in flight
        cycle(1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        got_pc.delete();
        repeat (8) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("redir_first", got_at(0), 32'h100);
        stale = 1'b0;
        foreach (got_pc[i]) if (got_pc[i] < 32'h100) stale = 1'b1;
        chk("redir_no_stale", 32'(stale), 32'd0);

        // Redirect coinciding with a response and ins_ready
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("redir_next_rv", 32'(s_rv), 32'd1);
        chk("redir_next_ra", s_ra, 32'h300);
        chk("redir_next_iv", 32'(s_iv), 32'd0);
        got_pc.delete();
        repeat (6) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("redir_same_first", got_at(0), 32'h300);

        // Unaligned redirect target and address wrap
        cycle(1'b1, 32'h203, 1'b1, 1'b1, 1'b1);
        chk("unaligned_ra_next", 32'(1), 32'(1) & 32'(s_rv == 1'b0));
        got_pc.delete();
        repeat (6) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("unaligned_first", got_at(0), 32'h200);
        cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b1);
        got_pc.delete();
        repeat (8) cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("wrap_0", got_at(0), 32'hFFFF_FFF8);
        chk("wrap_1", got_at(1), 32'hFFFF_FFFC);
        chk("wrap_2", got_at(2), 32'h0000_0000);

        // Fetch-to-decode latency from an empty queue
        repeat (6) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 32'h400, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("lat_rsp_cycle", 32'(s_iv), 32'(BYP));
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("lat_next_cycle", 32'(s_iv), 32'(!BYP));

        // Randomized traffic
        repeat (400) begin
            cycle($urandom_range(0, 15) == 0, $urandom, ($urandom % 4) != 0,
                  ($urandom % 3) != 0, ($urandom % 4) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
